amci_axi4lite_master: RTL and testbench

//  AXI4-Lite master engine sitting directly downstream of AMCI controllers.

---
 rtl/amci_axi4lite_master_pkg.sv | 33 +++
 rtl/amci_axi4lite_master.sv | 222 ++++++++++++++++++++++
 tb/tb_amci_axi4lite_master.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amci_axi4lite_master_pkg.sv
// amci_pkg: shared definitions for the AMCI-to-AXI4-Lite master engine.
// Provides default bus widths, AXI response codes, the retry counter width
// and the write/read channel state encodings.
package amci_pkg;

    // Default AXI widths; AMCI_MOSI/AMCI_MISO widths follow from these
    localparam int unsigned AMCI_DATA_W = 32;
    localparam int unsigned AMCI_ADDR_W = 32;

    // AXI4-Lite response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of the automatic write-retry counter
    localparam int unsigned RETRY_CNT_W = 4;

    // Write channel states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    // Read channel states
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

endpackage : amci_pkg

// File: rtl/amci_axi4lite_master.sv
// amci_axi4lite_master: turns AMCI write/read command pulses into AXI4-Lite
// transactions and reports idle flags, responses and read data on AMCI_MISO.
// The write and read channels are independent FSMs and may run concurrently.
// Optional feature: define AMCI_WRITE_RETRY_EN to reissue a write that ends
// in SLVERR, up to RETRY_LIMIT times, before reporting the final response.
module amci_axi4lite_master
    import amci_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = AMCI_DATA_W,
    parameter int unsigned AXI_ADDR_WIDTH = AMCI_ADDR_W
`ifdef AMCI_WRITE_RETRY_EN
    ,
    parameter int unsigned RETRY_LIMIT    = 15
`endif
) (
    input  logic                                         CLK,
    input  logic                                         RESETN,
    input  logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0]   AMCI_MOSI,
    output logic [AXI_DATA_WIDTH+5:0]                    AMCI_MISO,
    // write address channel
    output logic [AXI_ADDR_WIDTH-1:0]                    M_AXI_AWADDR,
    output logic [2:0]                                   M_AXI_AWPROT,
    output logic                                         M_AXI_AWVALID,
    input  logic                                         M_AXI_AWREADY,
    // write data channel
    output logic [AXI_DATA_WIDTH-1:0]                    M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]                  M_AXI_WSTRB,
    output logic                                         M_AXI_WVALID,
    input  logic                                         M_AXI_WREADY,
    // write response channel
    input  logic [1:0]                                   M_AXI_BRESP,
    input  logic                                         M_AXI_BVALID,
    output logic                                         M_AXI_BREADY,
    // read address channel
    output logic [AXI_ADDR_WIDTH-1:0]                    M_AXI_ARADDR,
    output logic [2:0]                                   M_AXI_ARPROT,
    output logic                                         M_AXI_ARVALID,
    input  logic                                         M_AXI_ARREADY,
    // read data channel
    input  logic [AXI_DATA_WIDTH-1:0]                    M_AXI_RDATA,
    input  logic [1:0]                                   M_AXI_RRESP,
    input  logic                                         M_AXI_RVALID,
    output logic                                         M_AXI_RREADY
);

    // AMCI_MOSI field offsets: {read, write, raddr, wdata, waddr}
    localparam int unsigned MOSI_WADDR_LSB = 0;
    localparam int unsigned MOSI_WDATA_LSB = AXI_ADDR_WIDTH;
    localparam int unsigned MOSI_RADDR_LSB = AXI_ADDR_WIDTH + AXI_DATA_WIDTH;
    localparam int unsigned MOSI_WRITE_BIT = 2*AXI_ADDR_WIDTH + AXI_DATA_WIDTH;
    localparam int unsigned MOSI_READ_BIT  = MOSI_WRITE_BIT + 1;

    // AMCI_MISO field offsets: {rresp, wresp, ridle, widle, rdata}
    localparam int unsigned MISO_RDATA_LSB = 0;
    localparam int unsigned MISO_WIDLE_BIT = AXI_DATA_WIDTH;
    localparam int unsigned MISO_RIDLE_BIT = AXI_DATA_WIDTH + 1;
    localparam int unsigned MISO_WRESP_LSB = AXI_DATA_WIDTH + 2;
    localparam int unsigned MISO_RRESP_LSB = AXI_DATA_WIDTH + 4;

    logic                      cmd_write;
    logic                      cmd_read;
    logic [AXI_ADDR_WIDTH-1:0] cmd_waddr;
    logic [AXI_ADDR_WIDTH-1:0] cmd_raddr;
    logic [AXI_DATA_WIDTH-1:0] cmd_wdata;

    wstate_t                   wstate;
    rstate_t                   rstate;
    logic [1:0]                wresp;
    logic [1:0]                rresp;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic                      widle_c;
    logic                      ridle_c;
    logic                      aw_done_c;
    logic                      w_done_c;

`ifdef AMCI_WRITE_RETRY_EN
    logic [RETRY_CNT_W-1:0]    retry_cnt;
`endif

    // Unpack the command bus
    assign cmd_waddr = AMCI_MOSI[MOSI_WADDR_LSB +: AXI_ADDR_WIDTH];
    assign cmd_wdata = AMCI_MOSI[MOSI_WDATA_LSB +: AXI_DATA_WIDTH];
    assign cmd_raddr = AMCI_MOSI[MOSI_RADDR_LSB +: AXI_ADDR_WIDTH];
    assign cmd_write = AMCI_MOSI[MOSI_WRITE_BIT];
    assign cmd_read  = AMCI_MOSI[MOSI_READ_BIT];

    // Idle flags include the incoming pulse so a new command reads busy at once
    assign widle_c = (wstate == W_IDLE) && !cmd_write;
    assign ridle_c = (rstate == R_IDLE) && !cmd_read;

    // Pack the status bus
    always_comb begin
        AMCI_MISO                                      = '0;
        AMCI_MISO[MISO_RDATA_LSB +: AXI_DATA_WIDTH]    = rdata;
        AMCI_MISO[MISO_WIDLE_BIT]                      = widle_c;
        AMCI_MISO[MISO_RIDLE_BIT]                      = ridle_c;
        AMCI_MISO[MISO_WRESP_LSB +: 2]                 = wresp;
        AMCI_MISO[MISO_RRESP_LSB +: 2]                 = rresp;
    end

    // Fixed attributes: unprivileged secure data access, full-word strobes
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // A channel is finished once its VALID is low or is being accepted now
    assign aw_done_c = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done_c  = !M_AXI_WVALID  || M_AXI_WREADY;

    // Write channel FSM: AW and W issued together, each released on its own READY
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wstate        <= W_IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            wresp         <= RESP_OKAY;
`ifdef AMCI_WRITE_RETRY_EN
            retry_cnt     <= '0;
`endif
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (cmd_write) begin
                        M_AXI_AWADDR  <= cmd_waddr;
                        M_AXI_WDATA   <= cmd_wdata;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
`ifdef AMCI_WRITE_RETRY_EN
                        retry_cnt     <= '0;
`endif
                        wstate        <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WVALID && M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (aw_done_c && w_done_c) begin
                        M_AXI_BREADY <= 1'b1;
                        wstate       <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
`ifdef AMCI_WRITE_RETRY_EN
                        // SLVERR replays the latched address/data while budget remains
                        if ((M_AXI_BRESP == RESP_SLVERR) &&
                            (retry_cnt < RETRY_CNT_W'(RETRY_LIMIT))) begin
                            retry_cnt     <= retry_cnt + 1'b1;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            wstate        <= W_ADDR;
                        end else begin
                            wresp  <= M_AXI_BRESP;
                            wstate <= W_IDLE;
                        end
`else
                        wresp  <= M_AXI_BRESP;
                        wstate <= W_IDLE;
`endif
                    end
                end
                default: begin
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    wstate        <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: AR handshake, then wait for a single R beat
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rstate        <= R_IDLE;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rdata         <= '0;
            rresp         <= RESP_OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (cmd_read) begin
                        M_AXI_ARADDR  <= cmd_raddr;
                        M_AXI_ARVALID <= 1'b1;
                        rstate        <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        rstate        <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (M_AXI_RVALID) begin
                        rdata        <= M_AXI_RDATA;
                        rresp        <= M_AXI_RRESP;
                        M_AXI_RREADY <= 1'b0;
                        rstate       <= R_IDLE;
                    end
                end
                default: begin
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    rstate        <= R_IDLE;
                end
            endcase
        end
    end

endmodule : amci_axi4lite_master

// File: tb/tb_amci_axi4lite_master.sv
// Bench for amci_axi4lite_master: directed scenarios followed by a random
// phase, checked by a scoreboard fed from the stimulus side. Honors
// AMCI_WRITE_RETRY_EN when it is defined for the build.
module tb_amci_axi4lite_master;
    import amci_pkg::*;

`ifdef AMCI_WRITE_RETRY_EN
    localparam int LIMIT = 15;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [97:0] mosi = '0;
    logic [37:0] miso;
    logic [31:0] awaddr, wdata, araddr, rdata_in;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp_in = 2'b00;

    always #5 clk = ~clk;

    amci_axi4lite_master dut (
        .CLK(clk), .RESETN(resetn), .AMCI_MOSI(mosi), .AMCI_MISO(miso),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata_in), .M_AXI_RRESP(rresp_in), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected traffic, filled by stimulus, drained by the monitor / slave
    logic [31:0] aw_exp[$];
    logic [31:0] w_exp[$];
    logic [31:0] ar_exp[$];
    logic [1:0]  bresp_plan[$];
    logic [1:0]  wresp_exp[$];
    logic [33:0] r_plan[$];
    logic [33:0] r_exp[$];

    // Slave latency per channel in cycles; -1 means random 0..4
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;

    int aw_hs_total = 0, w_hs_total = 0, b_hs_total = 0, ar_hs_total = 0, r_hs_total = 0;
    int last_w_low = 0, last_r_low = 0, last_aw_run = 0, last_w_run = 0;
    bit w_idle_seen = 1'b0, r_idle_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(4, 0)) : d;
    endfunction

    // Monitor (negedge) and slave responder (posedge + 1)
    initial begin : mon_slave
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit aw_pend, w_pend, ar_pend;
        logic [31:0] aw_pend_a, w_pend_d, ar_pend_a;
        bit prev_widle, prev_ridle, cw, cr;
        int w_low, r_low, aw_run, w_run;
        bit aw_act, w_act, ar_act, b_act, r_act;
        int aw_need, w_need, ar_need, b_need, r_need;
        int aw_age, w_age, ar_age, b_age, r_age;
        int b_owed, r_owed;
        aw_act = 0; w_act = 0; ar_act = 0; b_act = 0; r_act = 0;
        aw_need = 0; w_need = 0; ar_need = 0; b_need = 0; r_need = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        forever begin
            @(negedge clk);
            cw = miso[32];
            cr = miso[33];
            if (!resetn) begin
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                w_low = 0; r_low = 0; aw_run = 0; w_run = 0;
                w_idle_seen = 0; r_idle_seen = 0;
            end else begin
                // VALID with its payload must persist until READY
                if (aw_pend) chk("awvalid_hold", 64'({awvalid, awaddr}), 64'({1'b1, aw_pend_a}));
                if (w_pend)  chk("wvalid_hold",  64'({wvalid, wdata}),   64'({1'b1, w_pend_d}));
                if (ar_pend) chk("arvalid_hold", 64'({arvalid, araddr}), 64'({1'b1, ar_pend_a}));
                aw_pend = awvalid && !awready; aw_pend_a = awaddr;
                w_pend  = wvalid && !wready;   w_pend_d  = wdata;
                ar_pend = arvalid && !arready; ar_pend_a = araddr;
                hs_aw = awvalid && awready;
                hs_w  = wvalid && wready;
                hs_b  = bvalid && bready;
                hs_ar = arvalid && arready;
                hs_r  = rvalid && rready;
                if (awvalid) aw_run++;
                if (wvalid) w_run++;
                if (hs_aw) begin
                    last_aw_run = aw_run; aw_run = 0;
                    if (aw_exp.size() == 0) flag("aw_unexpected");
                    else chk("awaddr", 64'({awprot, awaddr}), 64'({3'b000, aw_exp.pop_front()}));
                end
                if (hs_w) begin
                    last_w_run = w_run; w_run = 0;
                    if (w_exp.size() == 0) flag("w_unexpected");
                    else chk("wdata", 64'({wstrb, wdata}), 64'({4'hF, w_exp.pop_front()}));
                end
                if (hs_ar) begin
                    if (ar_exp.size() == 0) flag("ar_unexpected");
                    else chk("araddr", 64'({arprot, araddr}), 64'({3'b000, ar_exp.pop_front()}));
                end
                if (cw && !prev_widle) begin
                    last_w_low = w_low;
                    if (wresp_exp.size() == 0) flag("wdone_unexpected");
                    else chk("wresp", 64'(miso[35:34]), 64'(wresp_exp.pop_front()));
                end
                if (cr && !prev_ridle) begin
                    last_r_low = r_low;
                    if (r_exp.size() == 0) flag("rdone_unexpected");
                    else chk("rresp_rdata", 64'({miso[37:36], miso[31:0]}), 64'(r_exp.pop_front()));
                end
                w_low = cw ? 0 : w_low + 1;
                r_low = cr ? 0 : r_low + 1;
                w_idle_seen = cw;
                r_idle_seen = cr;
            end
            prev_widle = cw;
            prev_ridle = cr;

            @(posedge clk);
            #1;
            if (!resetn) begin
                aw_act = 0; w_act = 0; ar_act = 0; b_act = 0; r_act = 0;
                aw_hs_total = 0; w_hs_total = 0; b_hs_total = 0; ar_hs_total = 0; r_hs_total = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            end else begin
                if (hs_aw) begin aw_hs_total++; aw_act = 0; end
                if (hs_w)  begin w_hs_total++;  w_act = 0;  end
                if (hs_ar) begin ar_hs_total++; ar_act = 0; end
                if (hs_b)  begin b_hs_total++;  b_act = 0; if (bresp_plan.size() > 0) void'(bresp_plan.pop_front()); end
                if (hs_r)  begin r_hs_total++;  r_act = 0; if (r_plan.size() > 0) void'(r_plan.pop_front()); end
                if (awvalid) begin
                    if (!aw_act) begin aw_act = 1; aw_need = pick(aw_dly); aw_age = 0; end else aw_age++;
                    awready = (aw_age >= aw_need);
                end else begin aw_act = 0; awready = (aw_dly == 0); end
                if (wvalid) begin
                    if (!w_act) begin w_act = 1; w_need = pick(w_dly); w_age = 0; end else w_age++;
                    wready = (w_age >= w_need);
                end else begin w_act = 0; wready = (w_dly == 0); end
                if (arvalid) begin
                    if (!ar_act) begin ar_act = 1; ar_need = pick(ar_dly); ar_age = 0; end else ar_age++;
                    arready = (ar_age >= ar_need);
                end else begin ar_act = 0; arready = (ar_dly == 0); end
                b_owed = ((aw_hs_total < w_hs_total) ? aw_hs_total : w_hs_total) - b_hs_total;
                if (b_owed > 0 && bresp_plan.size() > 0) begin
                    if (!b_act) begin b_act = 1; b_need = pick(b_dly); b_age = 0; end else b_age++;
                    bvalid = (b_age >= b_need);
                    bresp  = bresp_plan[0];
                end else begin b_act = 0; bvalid = 0; end
                r_owed = ar_hs_total - r_hs_total;
                if (r_owed > 0 && r_plan.size() > 0) begin
                    if (!r_act) begin r_act = 1; r_need = pick(r_dly); r_age = 0; end else r_age++;
                    rvalid = (r_age >= r_need);
                    {rresp_in, rdata_in} = r_plan[0];
                end else begin r_act = 0; rvalid = 0; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model of one write: the slave answers n_err SLVERRs then fin
    task automatic plan_write(input logic [31:0] a, input logic [31:0] d, input int n_err,
                              input logic [1:0] fin, output int att);
        logic [1:0] rep;
`ifdef AMCI_WRITE_RETRY_EN
        att = (n_err > LIMIT) ? LIMIT + 1 : n_err + 1;
        rep = (n_err > LIMIT) ? RESP_SLVERR : fin;
`else
        att = 1;
        rep = (n_err > 0) ? RESP_SLVERR : fin;
`endif
        for (int i = 0; i < att; i++) begin
            aw_exp.push_back(a);
            w_exp.push_back(d);
            bresp_plan.push_back((i < n_err) ? RESP_SLVERR : fin);
        end
        wresp_exp.push_back(rep);
    endtask

    task automatic plan_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rsp);
        ar_exp.push_back(a);
        r_plan.push_back({rsp, d});
        r_exp.push_back({rsp, d});
    endtask

    task automatic pulse(input bit dw, input bit dr, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra);
        mosi = {dr, dw, ra, wd, wa};
        tick();
        mosi[97:96] = 2'b00;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        while (!(w_idle_seen && r_idle_seen && wresp_exp.size() == 0 && r_exp.size() == 0)) begin
            if (n >= budget) begin
                flag({name, "_timeout"});
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    function automatic logic [1:0] rand_final();
        case ($urandom_range(2, 0))
            0:       return RESP_OKAY;
            1:       return RESP_EXOKAY;
            default: return RESP_DECERR;
        endcase
    endfunction

    initial begin : stim
        int att, base;
        logic [31:0] wa, wd, ra, rd;
        bit dw, dr;
        int n_err;
        resetn = 1'b0;
        repeat (3) tick();
        chk("reset_axi", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        chk("reset_miso", 64'(miso), 64'({2'b00, 2'b00, 1'b1, 1'b1, 32'h0}));
        resetn = 1'b1;
        repeat (2) tick();

        // Everything tied ready: write and read each take three busy cycles
        set_dly(0, 0, 0, 0, 0);
        plan_write(32'h4060_0004, 32'h0000_0048, 0, RESP_OKAY, att);
        pulse(1, 0, 32'h4060_0004, 32'h0000_0048, 32'h0);
        wait_quiet(50, "t1_write");
        chk("t1_widle_low_cycles", 64'(last_w_low), 64'(3));
        plan_read(32'h1234_5678, 32'hCAFE_0001, RESP_OKAY);
        pulse(0, 1, 32'h0, 32'h0, 32'h1234_5678);
        wait_quiet(50, "t1_read");
        chk("t1_ridle_low_cycles", 64'(last_r_low), 64'(3));

        // Write pulse held for two cycles: the second cycle is busy and ignored
        base = aw_hs_total;
        plan_write(32'h0000_0100, 32'h1111_2222, 0, RESP_EXOKAY, att);
        mosi = {1'b0, 1'b1, 32'h0, 32'h1111_2222, 32'h0000_0100};
        tick(); tick();
        mosi[97:96] = 2'b00;
        wait_quiet(50, "held_pulse");
        chk("held_pulse_aw_count", 64'(aw_hs_total - base), 64'(1));

        // AWREADY five cycles late, WREADY immediate
        set_dly(5, 0, 0, 0, 0);
        base = b_hs_total;
        plan_write(32'h0000_0200, 32'hA5A5_5A5A, 0, RESP_OKAY, att);
        pulse(1, 0, 32'h0000_0200, 32'hA5A5_5A5A, 32'h0);
        wait_quiet(80, "t2");
        chk("t2_awvalid_cycles", 64'(last_aw_run), 64'(6));
        chk("t2_wvalid_cycles", 64'(last_w_run), 64'(1));
        chk("t2_b_count", 64'(b_hs_total - base), 64'(1));

        // Read with the data beat four cycles late
        set_dly(0, 0, 0, 0, 4);
        plan_read(32'h4001_0000, 32'h0000_0005, RESP_OKAY);
        pulse(0, 1, 32'h0, 32'h0, 32'h4001_0000);
        wait_quiet(80, "t3");

        // SLVERR twice then OKAY, and a long SLVERR run past the retry budget
        set_dly(0, 0, 0, 0, 0);
        base = aw_hs_total;
        plan_write(32'h0000_0300, 32'h0BAD_F00D, 2, RESP_OKAY, att);
        pulse(1, 0, 32'h0000_0300, 32'h0BAD_F00D, 32'h0);
        wait_quiet(100, "t4");
        chk("t4_aw_count", 64'(aw_hs_total - base), 64'(att));
        base = aw_hs_total;
        plan_write(32'h0000_0304, 32'h0000_0017, 17, RESP_OKAY, att);
        pulse(1, 0, 32'h0000_0304, 32'h0000_0017, 32'h0);
        wait_quiet(300, "t4_limit");
        chk("t4_limit_aw_count", 64'(aw_hs_total - base), 64'(att));

        // Concurrent write and read with skewed readiness
        set_dly(2, 0, 1, 3, 2);
        plan_write(32'h0000_0400, 32'h5555_AAAA, 0, RESP_DECERR, att);
        plan_read(32'h0000_0500, 32'h7777_8888, RESP_EXOKAY);
        pulse(1, 1, 32'h0000_0400, 32'h5555_AAAA, 32'h0000_0500);
        wait_quiet(80, "t5");

        // Reset in the middle of the write address phase
        set_dly(10, 0, 0, 0, 0);
        plan_write(32'h0000_0600, 32'h6666_6666, 0, RESP_OKAY, att);
        pulse(1, 0, 32'h0000_0600, 32'h6666_6666, 32'h0);
        tick();
        resetn = 1'b0;
        aw_exp.delete(); w_exp.delete(); bresp_plan.delete(); wresp_exp.delete();
        tick();
        chk("t6_valids_after_reset", 64'({awvalid, wvalid, bready}), 64'(0));
        chk("t6_widle_after_reset", 64'(miso[32]), 64'(1));
        tick();
        resetn = 1'b1;
        set_dly(0, 0, 0, 0, 0);
        repeat (2) tick();
        plan_write(32'h0000_0700, 32'h7070_0707, 0, RESP_OKAY, att);
        pulse(1, 0, 32'h0000_0700, 32'h7070_0707, 32'h0);
        wait_quiet(50, "t6_after");

        // Random traffic with random slave timing
        set_dly(-1, -1, -1, -1, -1);
        for (int c = 0; c < 1500; c++) begin
            dw = w_idle_seen && ($urandom_range(2, 0) == 0);
            dr = r_idle_seen && ($urandom_range(2, 0) == 0);
            wa = $urandom; wd = $urandom; ra = $urandom; rd = $urandom;
            if (dw) begin
                n_err = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
                plan_write(wa, wd, n_err, rand_final(), att);
            end
            if (dr) plan_read(ra, rd, RESP_OKAY | 2'($urandom_range(3, 0)));
            pulse(dw, dr, wa, wd, ra);
        end
        wait_quiet(300, "random_drain");

        chk("left_aw", 64'(aw_exp.size()), 64'(0));
        chk("left_w", 64'(w_exp.size()), 64'(0));
        chk("left_ar", 64'(ar_exp.size()), 64'(0));
        chk("left_b", 64'(bresp_plan.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if the run ever stalls outright
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_amci_axi4lite_master
